// File: rtl/instr_seq.sv
// ---------------------------------------------------------------------------
// instr_seq -- six-state instruction sequencer.
//
// Runs a program of PROG_LEN instructions. Each instruction is fetched from
// memory, latched, decoded into datapath controls and written back over a
// fixed FETCH -> DECODE -> EXEC -> WB sequence. A run ends when the last
// instruction has been written back or when halt is raised during WB.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      run request (looked at in IDLE only)
//   halt       early-stop request (looked at in WB only)
//   mem_req    fetch request, high throughout FETCH
//   mem_valid  fetch data valid (looked at in FETCH only)
//   mem_data   instruction: [7:6] opcode, [5:4] reserved, [3:0] immediate
//   pc         address of the current instruction
//   OP         datapath operation: 0 = NOT, 1 = SHL
//   IMM_SEL    operand select: 0 = register, 1 = immediate
//   REG_EN     register-file write enable, one cycle per instruction in WB
//   imm        immediate field of the latched instruction
//   busy       high in every state except IDLE
//   done       one-cycle pulse when a run finishes
// ---------------------------------------------------------------------------
module instr_seq #(
    parameter int PC_W     = 4,
    parameter int PROG_LEN = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            halt,
    output logic            mem_req,
    input  logic            mem_valid,
    input  logic [7:0]      mem_data,
    output logic [PC_W-1:0] pc,
    output logic            OP,
    output logic            IMM_SEL,
    output logic            REG_EN,
    output logic [3:0]      imm,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_DONE
    } state_t;

    localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc_q;
    logic [1:0]      ir_op_q;
    logic [3:0]      ir_imm_q;
    logic            run_end;
    logic            unused_rsvd;

    // Bits [5:4] of the instruction word carry no meaning and are not stored.
    assign unused_rsvd = ^mem_data[5:4];

    // halt and the last-instruction condition collapse into one exit, so
    // both at once still yields a single pass through DONE.
    assign run_end = halt || (pc_q == LAST_PC);

    // ---- state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start)     state_nxt = S_FETCH;
            S_FETCH:  if (mem_valid) state_nxt = S_DECODE;
            S_DECODE:                state_nxt = S_EXEC;
            S_EXEC:                  state_nxt = S_WB;
            S_WB:                    state_nxt = run_end ? S_DONE : S_FETCH;
            S_DONE:                  state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    // ---- program counter and instruction register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= '0;
            ir_op_q  <= '0;
            ir_imm_q <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                pc_q <= '0;
            end else if (state == S_WB && !run_end) begin
                pc_q <= pc_q + PC_W'(1);
            end
            if (state == S_FETCH && mem_valid) begin
                ir_op_q  <= mem_data[7:6];
                ir_imm_q <= mem_data[3:0];
            end
        end
    end

    // ---- outputs (decoded from state only) ----
    always_comb begin
        mem_req = 1'b0;
        OP      = 1'b0;
        IMM_SEL = 1'b0;
        imm     = 4'h0;
        REG_EN  = 1'b0;
        done    = 1'b0;
        busy    = (state != S_IDLE);
        case (state)
            S_FETCH: mem_req = 1'b1;
            S_DECODE, S_EXEC: begin
                OP      = ir_op_q[0];
                IMM_SEL = ir_op_q[1];
                imm     = ir_imm_q;
            end
            S_WB: begin
                OP      = ir_op_q[0];
                IMM_SEL = ir_op_q[1];
                imm     = ir_imm_q;
                REG_EN  = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_instr_seq.sv
// ---------------------------------------------------------------------------
// tb_instr_seq -- self-checking bench for instr_seq (PROG_LEN = 4).
// Each program is described as a table of instruction words, fetch stalls
// and halt requests; expected outputs for every cycle follow from the
// instruction phase sequence and the opcode mapping.
// ---------------------------------------------------------------------------
module tb_instr_seq;

    localparam int PC_W     = 4;
    localparam int PROG_LEN = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            halt;
    logic            mem_req;
    logic            mem_valid;
    logic [7:0]      mem_data;
    logic [PC_W-1:0] pc;
    logic            OP;
    logic            IMM_SEL;
    logic            REG_EN;
    logic [3:0]      imm;
    logic            busy;
    logic            done;

    int   n_cmp = 0;
    int   n_err = 0;
    logic hold_start = 1'b0;

    logic [7:0] prog_dat  [PROG_LEN];
    int         prog_wait [PROG_LEN];
    logic       prog_halt [PROG_LEN];

    always #5 clk = ~clk;

    instr_seq #(
        .PC_W     (PC_W),
        .PROG_LEN (PROG_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .halt      (halt),
        .mem_req   (mem_req),
        .mem_valid (mem_valid),
        .mem_data  (mem_data),
        .pc        (pc),
        .OP        (OP),
        .IMM_SEL   (IMM_SEL),
        .REG_EN    (REG_EN),
        .imm       (imm),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs that the sequencer must ignore in the current phase get random values.
    task automatic noise();
        mem_valid = 1'($urandom);
        mem_data  = 8'($urandom);
        halt      = 1'($urandom);
        start     = hold_start ? 1'b1 : 1'($urandom);
    endtask

    // dec: decode outputs expected to reflect instruction word d.
    task automatic chk_ctl(input string ph, input logic e_req, input logic dec,
                           input logic [7:0] d, input logic e_we,
                           input logic e_busy, input logic e_done);
        chk({ph, ".mem_req"}, 32'(mem_req), 32'(e_req));
        chk({ph, ".OP"},      32'(OP),      32'(dec ? d[6] : 1'b0));
        chk({ph, ".IMM_SEL"}, 32'(IMM_SEL), 32'(dec ? d[7] : 1'b0));
        chk({ph, ".imm"},     32'(imm),     32'(dec ? d[3:0] : 4'h0));
        chk({ph, ".REG_EN"},  32'(REG_EN),  32'(e_we));
        chk({ph, ".busy"},    32'(busy),    32'(e_busy));
        chk({ph, ".done"},    32'(done),    32'(e_done));
    endtask

    // Entered in the first FETCH cycle of instruction idx; returns in the
    // cycle after its WB.
    task automatic do_instr(input int idx, output logic last);
        logic [7:0] d;
        d = prog_dat[idx];
        chk("fetch.pc", 32'(pc), idx);
        for (int w = 0; w < prog_wait[idx]; w++) begin
            chk_ctl("fetch_wait", 1'b1, 1'b0, d, 1'b0, 1'b1, 1'b0);
            noise();
            mem_valid = 1'b0;
            tick();
        end
        chk_ctl("fetch", 1'b1, 1'b0, d, 1'b0, 1'b1, 1'b0);
        noise();
        mem_valid = 1'b1;
        mem_data  = d;
        tick();
        chk_ctl("decode", 1'b0, 1'b1, d, 1'b0, 1'b1, 1'b0);
        noise();
        tick();
        chk_ctl("exec", 1'b0, 1'b1, d, 1'b0, 1'b1, 1'b0);
        noise();
        tick();
        chk_ctl("wb", 1'b0, 1'b1, d, 1'b1, 1'b1, 1'b0);
        chk("wb.pc", 32'(pc), idx);
        noise();
        halt = prog_halt[idx];
        tick();
        last = prog_halt[idx] || (idx == PROG_LEN - 1);
    endtask

    // Entered and left in an IDLE cycle.
    task automatic run_prog();
        logic last;
        int   idx;
        chk_ctl("idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        noise();
        start = 1'b1;
        tick();
        idx  = 0;
        last = 1'b0;
        while (!last) begin
            do_instr(idx, last);
            if (!last) idx++;
        end
        chk_ctl("done", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("done.pc", 32'(pc), idx);
        noise();
        tick();
        chk_ctl("idle_after", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        start     = 1'b0;
        halt      = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic set_plain();
        for (int i = 0; i < PROG_LEN; i++) begin
            prog_dat[i]  = {2'(i), 2'b00, 4'hA};
            prog_wait[i] = 0;
            prog_halt[i] = 1'b0;
        end
    endtask

    initial begin
        logic last;
        rst_n     = 1'b0;
        start     = 1'b0;
        halt      = 1'b0;
        mem_valid = 1'b0;
        mem_data  = 8'h00;
        repeat (3) tick();
        chk_ctl("reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("reset.pc", 32'(pc), 0);
        rst_n = 1'b1;
        tick();

        // IDLE holds without start regardless of other inputs.
        repeat (3) begin
            noise();
            start = 1'b0;
            tick();
            chk_ctl("idle_hold", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end

        // Opcodes 00,01,10,11 with imm A, no stalls, full run.
        set_plain();
        run_prog();

        // Fetch of pc=1 stalled three cycles.
        set_plain();
        prog_wait[1] = 3;
        run_prog();

        // Halt in the WB of pc=1.
        set_plain();
        prog_halt[1] = 1'b1;
        run_prog();

        // Halt together with the last instruction.
        set_plain();
        prog_halt[PROG_LEN-1] = 1'b1;
        run_prog();

        // start held high throughout a run.
        hold_start = 1'b1;
        set_plain();
        run_prog();
        hold_start = 1'b0;
        tick();
        chk_ctl("idle_gap", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Randomized programs.
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < PROG_LEN; i++) begin
                prog_dat[i]  = 8'($urandom);
                prog_wait[i] = $urandom_range(0, 3);
                prog_halt[i] = ($urandom_range(0, 4) == 0);
            end
            hold_start = 1'($urandom);
            run_prog();
            hold_start = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                noise();
                start = 1'b0;
                tick();
            end
        end

        // Reset during EXEC of pc=1, then restart from pc=0.
        set_plain();
        prog_dat[1] = 8'hC5;
        noise();
        start = 1'b1;
        tick();
        do_instr(0, last);
        chk("pre_rst.pc", 32'(pc), 1);
        noise();
        mem_valid = 1'b1;
        mem_data  = prog_dat[1];
        tick();
        noise();
        tick();
        chk_ctl("exec_pre_rst", 1'b0, 1'b1, 8'hC5, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_ctl("async_rst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("async_rst.pc", 32'(pc), 0);
        repeat (2) begin
            noise();
            tick();
            chk_ctl("in_rst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        rst_n     = 1'b1;
        start     = 1'b0;
        halt      = 1'b0;
        mem_valid = 1'b0;
        tick();
        set_plain();
        run_prog();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_seq.md
INSTR_SEQ -- requirements
Module: instr_seq

Interface
REQ-001 Parameter: PC_W, default 4, program counter width.
REQ-002 Parameter: PROG_LEN, default 16, number of instructions per run; legal range 1..2^PC_W.
REQ-003 Port: clk  in  1  single system clock; all state updates on rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: start  in  1  run request, sampled in IDLE only.
REQ-006 Port: halt  in  1  early-stop request, sampled in WB only.
REQ-007 Port: mem_req  out  1  instruction fetch request, high throughout FETCH.
REQ-008 Port: mem_valid  in  1  fetch data valid, sampled in FETCH only.
REQ-009 Port: mem_data  in  8  instruction word: [7:6] opcode, [5:4] unused, [3:0] immediate.
REQ-010 Port: pc  out  PC_W  address of the current instruction.
REQ-011 Port: OP  out  1  datapath operation select: 0 = NOT, 1 = SHL.
REQ-012 Port: IMM_SEL  out  1  operand select: 0 = register, 1 = immediate.
REQ-013 Port: REG_EN  out  1  register-file write enable.
REQ-014 Port: imm  out  4  immediate field of the latched instruction.
REQ-015 Port: busy  out  1  high in every state except IDLE.
REQ-016 Port: done  out  1  one-cycle pulse at end of a run.

Function
REQ-017 The FSM SHALL have exactly six states: IDLE, FETCH, DECODE, EXEC, WB, DONE.
REQ-018 IDLE: start=1 -> FETCH with pc cleared to 0; start=0 -> remain in IDLE.
REQ-019 FETCH: mem_req=1; mem_valid=1 -> IR latches mem_data and state goes to DECODE; otherwise remain in FETCH with no timeout.
REQ-020 DECODE -> EXEC -> WB SHALL each take exactly one cycle.
REQ-021 Opcode decode from IR[7:6]: 00 reg_not (OP=0, IMM_SEL=0); 01 reg_shl (OP=1, IMM_SEL=0); 10 imm_not (OP=0, IMM_SEL=1); 11 imm_shl (OP=1, IMM_SEL=1).
REQ-022 OP, IMM_SEL and imm SHALL be driven from IR in DECODE, EXEC and WB, and SHALL be 0 in all other states.
REQ-023 REG_EN SHALL be 1 only in WB, for exactly one cycle per instruction.
REQ-024 In WB, if halt=1 or pc==PROG_LEN-1 -> DONE with pc unchanged; otherwise pc increments by 1 and state goes to FETCH.
REQ-025 pc SHALL never wrap past PROG_LEN-1; the run completes at that point.
REQ-026 DONE: done=1 for one cycle, then IDLE.
REQ-027 Minimum instruction latency (FETCH entry to next FETCH entry) SHALL be 4 cycles when mem_valid is high on the first FETCH cycle; each added cycle of mem_valid low adds one cycle.
REQ-028 start outside IDLE, halt outside WB, and mem_valid outside FETCH SHALL be ignored.
REQ-029 If halt and pc==PROG_LEN-1 are both true in WB, the result SHALL be a single DONE pulse.
REQ-030 With PROG_LEN=1, a run SHALL execute exactly one instruction and then enter DONE.

Reset
REQ-031 rst_n=0 SHALL immediately, independent of clk, force state=IDLE, pc=0, IR=0, and all outputs to 0.
REQ-032 Reset asserted mid-run SHALL abort with no further REG_EN pulse and no done pulse; a subsequent start SHALL restart from pc=0.

Verification
REQ-033 Reset, then start pulse, then mem_valid=1 every fetch returning opcodes 00,01,10,11 with imm=4'hA -> (OP,IMM_SEL) = 00,10,01,11 in successive EXEC cycles; one REG_EN per instruction; 4-cycle spacing between instructions.
REQ-034 PROG_LEN=4, full run -> pc sequence 0,1,2,3; done pulses once, 1 cycle after the fourth REG_EN; busy then drops.
REQ-035 mem_valid held low for 3 cycles during FETCH -> FETCH lasts 4 cycles, mem_req stays high, and no decode outputs are asserted.
REQ-036 halt=1 in the WB of pc=1 -> DONE with pc=1; no FETCH of pc=2.
REQ-037 rst_n asserted low during EXEC -> all outputs 0 in the same cycle; after release, start yields a fetch at pc=0.
REQ-038 start held high throughout a run and mem_valid toggled outside FETCH -> no effect on sequence; a new run begins only after IDLE is re-entered.
